// File: rtl/sw_debounce.sv
// Slide-switch front end: two-flop synchroniser, shared sample-tick prescaler,
// per-bit stability filter, and registered one-cycle rise/fall/change pulses.
module sw_debounce #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIV    = 100000,
    parameter int unsigned STABLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_OUT,
    output logic [WIDTH-1:0] SW_RISE,
    output logic [WIDTH-1:0] SW_FALL,
    output logic             SW_CHG,
    output logic             TICK
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam logic [PW-1:0] PC_LAST  = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [PW-1:0]    pc;
    logic [PW-1:0]    pc_next;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    always_comb begin
        pc_next = (pc == PC_LAST) ? '0 : pc + 1'b1;
    end

    // TICK is registered from pc_next so it reads 0 through reset even when DIV=1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            pc   <= '0;
            TICK <= 1'b0;
        end else begin
            s1   <= SW;
            s2   <= s1;
            pc   <= pc_next;
            TICK <= (pc_next == PC_LAST);
        end
    end

    always_comb begin
        out_next  = SW_OUT;
        rise_next = '0;
        fall_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = cnt[i];
            if (TICK) begin
                if (s2[i] == SW_OUT[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    out_next[i]  = s2[i];
                    cnt_next[i]  = '0;
                    rise_next[i] = s2[i];
                    fall_next[i] = ~s2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SW_OUT  <= '0;
            SW_RISE <= '0;
            SW_FALL <= '0;
            SW_CHG  <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            SW_OUT  <= out_next;
            SW_RISE <= rise_next;
            SW_FALL <= fall_next;
            SW_CHG  <= |(rise_next | fall_next);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule
